// File: rtl/sample_flow_pkg.sv
// rtl/sample_flow_pkg.sv - shared types and constants for sample_flow_capture
// Purpose: operating-mode and capture-FSM encodings used by the sampler and its bench.
// Ports: none (package).
package sample_flow_pkg;

  localparam int MODE_W  = 2;
  localparam int STATE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LIVE    = 2'd0,
    HOLD    = 2'd1,
    CAPTURE = 2'd2,
    DELTA   = 2'd3
  } mode_e;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FILL    = 2'd2,
    READOUT = 2'd3
  } cap_state_e;

endpackage

// File: rtl/sample_flow_prescaler.sv
// rtl/sample_flow_prescaler.sv - decimation counter producing the sample strobe
// Purpose: emits strobe once every div+1 enabled cycles.
// Ports: clk, reset (async, active-high), ena (count enable),
//        div (decimation divisor), strobe (one-cycle sample strobe).
module sample_flow_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_hit;

  // Equality compare only: lowering div below the current count lets the
  // counter run on and wrap through 2^DIV_W before the next strobe.
  assign w_hit  = (r_cnt == div);
  assign strobe = ena & w_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (ena) begin
      r_cnt <= w_hit ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sample_flow_capture.sv
// rtl/sample_flow_capture.sv - decimated input sampler with live/hold/capture/delta modes
// Purpose: samples din at a programmable rate; in CAPTURE mode records a
//          triggered burst of DEPTH samples and plays it back on rd_en.
// Ports: clk, reset (async, active-high), ena (global enable), din (input bus),
//        mode (0 LIVE,1 HOLD,2 CAPTURE,3 DELTA), div (decimation), trig (capture
//        trigger, edge detected), rd_en (pop buffered sample), dout (sample),
//        dout_valid (update pulse), buf_count (buffer fill), cap_state (FSM state),
//        overrun (sticky trigger-while-busy flag).
module sample_flow_capture
  import sample_flow_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int DIV_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ena,
  input  logic [WIDTH-1:0]           din,
  input  logic [MODE_W-1:0]          mode,
  input  logic [DIV_W-1:0]           div,
  input  logic                       trig,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] buf_count,
  output logic [STATE_W-1:0]         cap_state,
  output logic                       overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH-1);

  mode_e            w_mode;
  logic             w_strobe;
  logic             w_trig_rise;
  logic             w_wr;
  logic             w_rd;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic [CNT_W-1:0] r_count;
  cap_state_e       r_state;
  logic             r_overrun;
  logic             r_trig_d;
  logic [WIDTH-1:0] r_prev;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;

  sample_flow_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .ena    (ena),
    .div    (div),
    .strobe (w_strobe)
  );

  assign w_mode      = mode_e'(mode);
  assign w_trig_rise = trig & ~r_trig_d;
  assign w_wr = (w_mode == CAPTURE) && (r_state == FILL) && w_strobe;
  assign w_rd = ena && (w_mode == CAPTURE) && (r_state == READOUT) && rd_en && (r_count != '0);

  // Storage has no reset: contents are only ever read after being written.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_count      <= '0;
      r_state      <= IDLE;
      r_overrun    <= 1'b0;
      r_trig_d     <= 1'b0;
      r_prev       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
    end else if (ena) begin
      r_dout_valid <= 1'b0;
      r_trig_d     <= trig;
      case (w_mode)
        LIVE: begin
          if (w_strobe) begin
            r_dout       <= din;
            r_dout_valid <= 1'b1;
          end
        end
        HOLD: begin
        end
        DELTA: begin
          if (w_strobe) begin
            r_dout       <= din - r_prev;
            r_prev       <= din;
            r_dout_valid <= 1'b1;
          end
        end
        CAPTURE: begin
          case (r_state)
            IDLE: r_state <= ARMED;
            ARMED: begin
              if (w_trig_rise) r_state <= FILL;
            end
            FILL: begin
              if (w_trig_rise) r_overrun <= 1'b1;
              if (w_wr) begin
                r_wptr  <= r_wptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(1);
                // Leave FILL on the edge that commits the final entry.
                if (r_count == LAST_SLOT) r_state <= READOUT;
              end
            end
            READOUT: begin
              if (w_trig_rise) r_overrun <= 1'b1;
              if (w_rd) begin
                r_dout       <= r_mem[r_rptr];
                r_dout_valid <= 1'b1;
                r_rptr       <= r_rptr + PTR_W'(1);
                r_count      <= r_count - CNT_W'(1);
                if (r_count == CNT_W'(1)) r_state <= ARMED;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
        default: begin
        end
      endcase
      // Leaving CAPTURE abandons any burst; dout keeps its last value.
      if (w_mode != CAPTURE) begin
        r_state   <= IDLE;
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_count   <= '0;
        r_overrun <= 1'b0;
      end
      // Holding prev at zero outside DELTA makes the first delta equal din.
      if (w_mode != DELTA) begin
        r_prev <= '0;
      end
    end else begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid & ena;
  assign buf_count  = r_count;
  assign cap_state  = r_state;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sample_flow_capture.sv
// tb/tb_sample_flow_capture.sv - self-checking bench for sample_flow_capture
module tb_sample_flow_capture;

  localparam logic [1:0] M_LIVE = 2'd0, M_HOLD = 2'd1, M_CAP = 2'd2, M_DELTA = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_FILL = 2'd2, S_READ = 2'd3;

  logic       clk;
  logic       reset;
  logic       ena;
  logic [7:0] din;
  logic [1:0] mode;
  logic [7:0] div;
  logic       trig;
  logic       rd_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic [4:0] buf_count;
  logic [1:0] cap_state;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int n_edges = 0;
  int edge_idx = 0;

  sample_flow_capture #(.WIDTH(8), .DEPTH(16), .DIV_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .din        (din),
    .mode       (mode),
    .div        (div),
    .trig       (trig),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .buf_count  (buf_count),
    .cap_state  (cap_state),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    edge_idx = n_edges;
    n_edges++;
  endtask

  // Edge k after reset release strobes when k mod (div+1) == div (ena held high).
  function automatic bit strb();
    return (edge_idx % (int'(div) + 1)) == int'(div);
  endfunction

  task automatic do_reset(input logic [1:0] m, input logic [7:0] d);
    reset = 1'b1; ena = 1'b1; mode = m; div = d;
    din = 8'h00; trig = 1'b0; rd_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_edges = 0;
  endtask

  task automatic test_reset();
    do_reset(M_LIVE, 8'd0);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    total++; if (buf_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", buf_count); end
    total++; if (cap_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", cap_state); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_live();
    logic [7:0] exp_d;
    bit         exp_v;
    do_reset(M_LIVE, 8'd0);
    for (int i = 0; i < 6; i++) begin
      din = 8'(i);
      tick();
      total++;
      if (dout !== 8'(i) || dout_valid !== 1'b1) begin
        bad++; $display("FAIL live_ramp[%0d] got dout=%h v=%b exp dout=%h v=1", i, dout, dout_valid, 8'(i));
      end
    end
    ena = 1'b0; din = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (dout !== 8'h05 || dout_valid !== 1'b0) begin
        bad++; $display("FAIL live_ena_low[%0d] got dout=%h v=%b exp dout=05 v=0", i, dout, dout_valid);
      end
    end
    ena = 1'b1;
    do_reset(M_LIVE, 8'($urandom_range(1, 4)));
    exp_d = 8'h00;
    for (int i = 0; i < 30; i++) begin
      din = 8'($urandom);
      tick();
      exp_v = strb();
      if (exp_v) exp_d = din;
      total++;
      if (dout !== exp_d || dout_valid !== exp_v) begin
        bad++; $display("FAIL live_rand[%0d] div=%0d got dout=%h v=%b exp dout=%h v=%b", i, div, dout, dout_valid, exp_d, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp_d;
    bit         exp_v;
    do_reset(M_LIVE, 8'd3);
    din = 8'hA5; exp_d = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_v = strb();
      if (exp_v) exp_d = 8'hA5;
      total++;
      if (dout !== exp_d || dout_valid !== exp_v) begin
        bad++; $display("FAIL live_div3[%0d] got dout=%h v=%b exp dout=%h v=%b", i, dout, dout_valid, exp_d, exp_v);
      end
    end
    mode = M_HOLD; din = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (dout !== 8'hA5 || dout_valid !== 1'b0) begin
        bad++; $display("FAIL hold[%0d] got dout=%h v=%b exp dout=a5 v=0", i, dout, dout_valid);
      end
    end
  endtask

  task automatic test_delta();
    logic [7:0] seq [3];
    logic [7:0] res [3];
    logic [7:0] prev, exp_d;
    bit         exp_v;
    seq = '{8'h10, 8'h15, 8'h05};
    res = '{8'h10, 8'h05, 8'hF0};
    do_reset(M_DELTA, 8'd0);
    for (int i = 0; i < 3; i++) begin
      din = seq[i];
      tick();
      total++;
      if (dout !== res[i] || dout_valid !== 1'b1) begin
        bad++; $display("FAIL delta_fixed[%0d] got dout=%h v=%b exp dout=%h v=1", i, dout, dout_valid, res[i]);
      end
    end
    do_reset(M_DELTA, 8'($urandom_range(0, 3)));
    prev = 8'h00; exp_d = 8'h00;
    for (int i = 0; i < 34; i++) begin
      mode = (i == 15 || i == 16) ? M_LIVE : M_DELTA;
      din = 8'($urandom);
      tick();
      exp_v = strb();
      if (mode == M_LIVE) begin
        if (exp_v) exp_d = din;
        prev = 8'h00;
      end else if (exp_v) begin
        exp_d = din - prev;
        prev = din;
      end
      total++;
      if (dout !== exp_d || dout_valid !== exp_v) begin
        bad++; $display("FAIL delta_rand[%0d] div=%0d got dout=%h v=%b exp dout=%h v=%b", i, div, dout, dout_valid, exp_d, exp_v);
      end
    end
  endtask

  task automatic test_capture();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    do_reset(M_CAP, 8'd0);
    tick();
    total++; if (cap_state !== S_ARMED) begin bad++; $display("FAIL cap_arm got=%0d exp=1", cap_state); end
    din = 8'h20; trig = 1'b1;
    tick();
    trig = 1'b0;
    total++; if (cap_state !== S_FILL || buf_count !== 5'd0) begin
      bad++; $display("FAIL cap_trig got state=%0d cnt=%0d exp state=2 cnt=0", cap_state, buf_count);
    end
    q = {};
    for (int i = 0; i < 16; i++) begin
      din = 8'h21 + 8'(i);
      tick();
      q.push_back(din);
      total++;
      if (buf_count !== 5'(q.size()) || cap_state !== ((q.size() == 16) ? S_READ : S_FILL)) begin
        bad++; $display("FAIL cap_fill[%0d] got cnt=%0d state=%0d exp cnt=%0d", i, buf_count, cap_state, q.size());
      end
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      exp_d = q.pop_front();
      total++;
      if (dout !== exp_d || dout_valid !== 1'b1 || buf_count !== 5'(q.size())) begin
        bad++; $display("FAIL cap_read[%0d] got dout=%h v=%b cnt=%0d exp dout=%h v=1 cnt=%0d", i, dout, dout_valid, buf_count, exp_d, q.size());
      end
      rd_en = 1'b0;
      tick();
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL cap_read_gap[%0d] got v=%b exp v=0", i, dout_valid); end
    end
    total++; if (cap_state !== S_ARMED || buf_count !== 5'd0) begin
      bad++; $display("FAIL cap_done got state=%0d cnt=%0d exp state=1 cnt=0", cap_state, buf_count);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    bit         ov;
    int         i;
    do_reset(M_CAP, 8'd1);
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (dout_valid !== 1'b0 || buf_count !== 5'd0 || cap_state !== S_ARMED) begin
      bad++; $display("FAIL ovr_rd_armed got v=%b cnt=%0d state=%0d exp v=0 cnt=0 state=1", dout_valid, buf_count, cap_state);
    end
    trig = 1'b1;
    tick();
    trig = 1'b0;
    q = {}; ov = 1'b0; i = 0;
    while (q.size() < 16 && i < 100) begin
      din = 8'($urandom);
      trig = (i == 5);
      tick();
      if (trig) ov = 1'b1;
      if (strb()) q.push_back(din);
      total++;
      if (buf_count !== 5'(q.size()) || overrun !== ov || cap_state !== ((q.size() == 16) ? S_READ : S_FILL)) begin
        bad++; $display("FAIL ovr_fill[%0d] got cnt=%0d ovr=%b state=%0d exp cnt=%0d ovr=%b", i, buf_count, overrun, cap_state, q.size(), ov);
      end
      i++;
    end
    trig = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      exp_d = q.pop_front();
      total++;
      if (dout !== exp_d || dout_valid !== 1'b1) begin
        bad++; $display("FAIL ovr_read[%0d] got dout=%h v=%b exp dout=%h v=1", k, dout, dout_valid, exp_d);
      end
    end
    mode = M_LIVE;
    tick();
    total++; if (overrun !== 1'b0 || cap_state !== S_IDLE || buf_count !== 5'd0) begin
      bad++; $display("FAIL ovr_to_live got ovr=%b state=%0d cnt=%0d exp ovr=0 state=0 cnt=0", overrun, cap_state, buf_count);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    do_reset(M_LIVE, 8'd0);
    din = 8'h5A;
    tick();
    mode = M_CAP;
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 0; i < 7; i++) begin
      din = 8'($urandom);
      trig = (i == 3);
      tick();
    end
    trig = 1'b0;
    total++; if (buf_count !== 5'd7 || overrun !== 1'b1 || dout !== 8'h5A) begin
      bad++; $display("FAIL arst_pre got cnt=%0d ovr=%b dout=%h exp cnt=7 ovr=1 dout=5a", buf_count, overrun, dout);
    end
    #2;
    reset = 1'b1;
    #1;
    total++; if ({dout, dout_valid, buf_count, cap_state, overrun} !== 17'd0) begin
      bad++; $display("FAIL arst_now got dout=%h v=%b cnt=%0d state=%0d ovr=%b exp all 0", dout, dout_valid, buf_count, cap_state, overrun);
    end
    do_reset(M_CAP, 8'd0);
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    q = {};
    for (int i = 0; i < 16; i++) begin
      din = 8'($urandom);
      tick();
      q.push_back(din);
    end
    total++; if (buf_count !== 5'd16 || cap_state !== S_READ) begin
      bad++; $display("FAIL arst_refill got cnt=%0d state=%0d exp cnt=16 state=3", buf_count, cap_state);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_d = q.pop_front();
      total++;
      if (dout !== exp_d || dout_valid !== 1'b1 || buf_count !== 5'(q.size())) begin
        bad++; $display("FAIL arst_b2b[%0d] got dout=%h v=%b cnt=%0d exp dout=%h v=1 cnt=%0d", i, dout, dout_valid, buf_count, exp_d, q.size());
      end
    end
    tick();
    rd_en = 1'b0;
    total++; if (dout_valid !== 1'b0 || buf_count !== 5'd0 || cap_state !== S_ARMED) begin
      bad++; $display("FAIL arst_extra_rd got v=%b cnt=%0d state=%0d exp v=0 cnt=0 state=1", dout_valid, buf_count, cap_state);
    end
  endtask

  initial begin
    test_reset();
    test_live();
    test_hold();
    test_delta();
    test_capture();
    test_overrun();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
